// File: rtl/rx_parity_checker_if.sv
// Frame-in / checked-data-out bundle for the UART Rx parity checker.
// master: Rx front end plus consumer; slave: the checker.
interface rx_parity_checker_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [1:0]           parity_mode;
  logic                 frame_valid;
  logic [DATA_BITS:0]   frame;
  logic                 data_ready;
  logic                 data_valid;
  logic [DATA_BITS-1:0] data;
  logic                 parity_err;

  modport master (
    output parity_mode,
    output frame_valid,
    output frame,
    output data_ready,
    input  data_valid,
    input  data,
    input  parity_err
  );

  modport slave (
    input  parity_mode,
    input  frame_valid,
    input  frame,
    input  data_ready,
    output data_valid,
    output data,
    output parity_err
  );
endinterface

// File: rtl/rx_parity_checker.sv
// Registered UART Rx parity checker with a one-deep valid/ready output buffer
// and saturating parity-error / overrun statistics.
module rx_parity_checker #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rx_parity_checker_if.slave   bus,
  input  logic                 clr_stats,
  output logic                 err_pulse,
  output logic                 overrun,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] ovr_count
);

  typedef enum logic [1:0] {
    ModeNone = 2'b00,
    ModeEven = 2'b01,
    ModeOdd  = 2'b10,
    ModeMark = 2'b11
  } parity_mode_e;

  logic                 data_valid_q, data_valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 parity_err_q, parity_err_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 overrun_q, overrun_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [ERR_CNT_W-1:0] ovr_count_q, ovr_count_d;

  logic [DATA_BITS-1:0] payload;
  logic                 rx_parity;
  logic                 calc_parity;
  logic                 frame_err;
  logic                 accept;
  logic                 transfer;
  logic                 drop;

  assign payload     = bus.frame[DATA_BITS:1];
  assign rx_parity   = bus.frame[0];
  assign calc_parity = ^payload;

  always_comb begin
    frame_err = 1'b0;
    unique case (parity_mode_e'(bus.parity_mode))
      ModeNone: frame_err = 1'b0;
      ModeEven: frame_err = (rx_parity != calc_parity);
      ModeOdd:  frame_err = (rx_parity != ~calc_parity);
      ModeMark: frame_err = (rx_parity != 1'b1);
      default:  frame_err = 1'b0;
    endcase
  end

  assign accept   = bus.frame_valid && (!data_valid_q || bus.data_ready);
  assign transfer = data_valid_q && bus.data_ready;
  assign drop     = bus.frame_valid && data_valid_q && !bus.data_ready;

  always_comb begin
    data_valid_d = data_valid_q;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    err_pulse_d  = accept && frame_err;
    overrun_d    = drop;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    ovr_count_d  = ovr_count_q;

    // An accept in a transfer cycle refills the buffer, keeping valid high.
    if (accept) begin
      data_valid_d = 1'b1;
      data_d       = payload;
      parity_err_d = frame_err;
    end else if (transfer) begin
      data_valid_d = 1'b0;
    end

    if (clr_stats) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
      ovr_count_d  = '0;
    end else begin
      if (err_pulse_d) begin
        err_sticky_d = 1'b1;
        if (err_count_q != {ERR_CNT_W{1'b1}}) err_count_d = err_count_q + 1'b1;
      end
      if (drop && (ovr_count_q != {ERR_CNT_W{1'b1}})) ovr_count_d = ovr_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid_q <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      overrun_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      ovr_count_q  <= '0;
    end else begin
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      err_pulse_q  <= err_pulse_d;
      overrun_q    <= overrun_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      ovr_count_q  <= ovr_count_d;
    end
  end

  assign bus.data_valid = data_valid_q;
  assign bus.data       = data_q;
  assign bus.parity_err = parity_err_q;
  assign err_pulse      = err_pulse_q;
  assign overrun        = overrun_q;
  assign err_sticky     = err_sticky_q;
  assign err_count      = err_count_q;
  assign ovr_count      = ovr_count_q;

endmodule

// File: tb/tb_rx_parity_checker.sv
// Directed plus randomized bench for rx_parity_checker; every cycle is compared
// against a transaction-level buffer/counter model.
module tb_rx_parity_checker;
  localparam int unsigned DB  = 8;
  localparam int unsigned CW  = 2;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_stats;
  logic          err_pulse;
  logic          overrun;
  logic          err_sticky;
  logic [CW-1:0] err_count;
  logic [CW-1:0] ovr_count;

  rx_parity_checker_if #(.DATA_BITS(DB)) bus ();

  rx_parity_checker #(
    .DATA_BITS(DB),
    .ERR_CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_stats (clr_stats),
    .err_pulse (err_pulse),
    .overrun   (overrun),
    .err_sticky(err_sticky),
    .err_count (err_count),
    .ovr_count (ovr_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: what the outputs must show after the next edge.
  bit          m_valid;
  bit [DB-1:0] m_data;
  bit          m_perr;
  bit          m_epulse;
  bit          m_ovr;
  bit          m_sticky;
  int          m_ecnt;
  int          m_ocnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit ref_err(input bit [1:0] mode, input bit [DB:0] fr);
    int ones;
    ones = $countones(fr[DB:1]);
    case (mode)
      2'd0:    return 1'b0;
      2'd1:    return fr[0] != bit'(ones % 2);
      2'd2:    return fr[0] != bit'((ones + 1) % 2);
      default: return fr[0] != 1'b1;
    endcase
  endfunction

  task automatic cycle(input bit fv, input bit [DB:0] fr, input bit [1:0] mode,
                       input bit rdy, input bit clr, input bit r);
    bit busy;
    bus.frame_valid  = fv;
    bus.frame        = fr;
    bus.parity_mode  = mode;
    bus.data_ready   = rdy;
    clr_stats        = clr;
    rst              = r;
    busy = m_valid && !rdy;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 0; m_data = '0; m_perr = 0; m_epulse = 0; m_ovr = 0;
      m_sticky = 0; m_ecnt = 0; m_ocnt = 0;
    end else begin
      m_epulse = 0;
      if (fv && !busy) begin
        m_valid  = 1;
        m_data   = fr[DB:1];
        m_perr   = ref_err(mode, fr);
        m_epulse = m_perr;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      m_ovr = fv && busy;
      if (clr) begin
        m_ecnt = 0; m_ocnt = 0; m_sticky = 0;
      end else begin
        if (m_epulse) m_sticky = 1;
        m_ecnt = (m_ecnt + int'(m_epulse) > SAT) ? SAT : m_ecnt + int'(m_epulse);
        m_ocnt = (m_ocnt + int'(m_ovr) > SAT) ? SAT : m_ocnt + int'(m_ovr);
      end
    end
    check("data_valid", 32'(bus.data_valid), 32'(m_valid));
    check("data",       32'(bus.data),       32'(m_data));
    check("parity_err", 32'(bus.parity_err), 32'(m_perr));
    check("err_pulse",  32'(err_pulse),      32'(m_epulse));
    check("overrun",    32'(overrun),        32'(m_ovr));
    check("err_sticky", 32'(err_sticky),     32'(m_sticky));
    check("err_count",  32'(err_count),      32'(m_ecnt));
    check("ovr_count",  32'(ovr_count),      32'(m_ocnt));
  endtask

  initial begin
    m_valid = 0; m_data = '0; m_perr = 0; m_epulse = 0; m_ovr = 0;
    m_sticky = 0; m_ecnt = 0; m_ocnt = 0;
    rst = 1'b1; clr_stats = 1'b0;
    bus.frame_valid = 1'b0; bus.frame = '0; bus.parity_mode = 2'd0; bus.data_ready = 1'b0;

    cycle(0, 9'h000, 2'd0, 0, 0, 1);
    cycle(0, 9'h000, 2'd0, 0, 0, 1);
    cycle(0, 9'h000, 2'd0, 1, 0, 0);

    // Even mode good / bad, then odd mode on the same bad-for-even frame.
    cycle(1, {8'hAA, 1'b0}, 2'd1, 1, 0, 0);
    cycle(0, 9'h000, 2'd1, 1, 0, 0);
    cycle(1, {8'hAB, 1'b0}, 2'd1, 1, 0, 0);
    cycle(0, 9'h000, 2'd1, 1, 0, 0);
    cycle(1, {8'hAB, 1'b0}, 2'd2, 1, 0, 0);
    cycle(0, 9'h000, 2'd2, 1, 0, 0);
    // Mark then none.
    cycle(1, {8'h3C, 1'b0}, 2'd3, 1, 0, 0);
    cycle(1, {8'h3C, 1'b0}, 2'd0, 1, 0, 0);
    cycle(0, 9'h000, 2'd0, 1, 0, 0);

    // Overrun while stalled; mode change must not touch the buffered flag.
    cycle(1, {8'h11, 1'b1}, 2'd1, 0, 0, 0);
    cycle(0, 9'h000, 2'd2, 0, 0, 0);
    cycle(1, {8'h22, 1'b0}, 2'd1, 0, 0, 0);
    cycle(0, 9'h000, 2'd0, 0, 0, 0);
    cycle(0, 9'h000, 2'd0, 1, 0, 0);
    cycle(0, 9'h000, 2'd0, 1, 0, 0);

    // Back-to-back strobes at full throughput.
    for (int i = 0; i < 6; i++) cycle(1, {8'(8'h40 + i), 1'b0}, 2'd1, 1, 0, 0);
    cycle(0, 9'h000, 2'd1, 1, 0, 0);

    // Saturation of the error counter, then clear in the same cycle as an error.
    for (int i = 0; i < 5; i++) cycle(1, {8'hAB, 1'b0}, 2'd1, 1, 0, 0);
    cycle(1, {8'h01, 1'b0}, 2'd1, 1, 1, 0);
    cycle(0, 9'h000, 2'd1, 1, 0, 0);

    // Reset while holding data with a strobe present.
    cycle(1, {8'h5A, 1'b0}, 2'd1, 0, 0, 0);
    cycle(1, {8'hC3, 1'b0}, 2'd1, 0, 0, 1);
    cycle(0, 9'h000, 2'd1, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      cycle(bit'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
